// File: rtl/dcm_sup_pkg.sv
// Shared state encoding and default timing constants for the DCM lock supervisor.
package dcm_sup_pkg;

    localparam logic [2:0] ST_RST1   = 3'd0;
    localparam logic [2:0] ST_WAIT1  = 3'd1;
    localparam logic [2:0] ST_RST2   = 3'd2;
    localparam logic [2:0] ST_WAIT2  = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;
    localparam logic [2:0] ST_RUN    = 3'd5;
    localparam logic [2:0] ST_FAULT  = 3'd6;

    typedef enum logic [2:0] {
        S_RST1   = ST_RST1,
        S_WAIT1  = ST_WAIT1,
        S_RST2   = ST_RST2,
        S_WAIT2  = ST_WAIT2,
        S_SETTLE = ST_SETTLE,
        S_RUN    = ST_RUN,
        S_FAULT  = ST_FAULT
    } state_t;

    localparam int DEF_RST_CYCLES    = 8;
    localparam int DEF_LOCK_TIMEOUT  = 48000;
    localparam int DEF_SETTLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRY     = 4;
    localparam int DEF_CNT_W         = 16;

    // Lock-loss counter holds at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer bringing an asynchronous DCM LOCKED flag into the supervisor clock.
module lock_sync (
    input  logic clk,
    input  logic srst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= async_in;
            sync_reg <= meta_reg;
        end
    end

    assign sync_out = sync_reg;

endmodule

// File: rtl/dcm_lock_supervisor.sv
// Sequences reset and lock acquisition of the cascaded DCM_BUS / DCM_CMD pair and holds
// fabric reset until both are locked and stable; retries, re-acquires and latches FAULT.
module dcm_lock_supervisor
    import dcm_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       BUS_CLK,
    input  logic       BUS_RST,
    input  logic       RESTART,
    input  logic       LOCKED1,
    input  logic       LOCKED2,
    output logic       DCM1_RST,
    output logic       DCM2_RST,
    output logic       SYS_RST,
    output logic       READY,
    output logic       FAULT,
    output logic [2:0] RETRY_CNT,
    output logic [7:0] LOSS_CNT
);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]       MAX_RETRY_W = 3'(MAX_RETRY);

    logic [1:0] locked_raw;
    logic [1:0] locked_sync;
    logic       l1s;
    logic       l2s;

    assign locked_raw = {LOCKED2, LOCKED1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            lock_sync u_lock_sync (
                .clk      (BUS_CLK),
                .srst     (BUS_RST),
                .async_in (locked_raw[gi]),
                .sync_out (locked_sync[gi])
            );
        end
    endgenerate

    assign l1s = locked_sync[0];
    assign l2s = locked_sync[1];

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] timer_reg;
    logic [CNT_W-1:0] timer_next;
    logic [2:0]       retry_reg;
    logic [2:0]       retry_next;
    logic [7:0]       loss_reg;
    logic [7:0]       loss_next;
    logic             fail;

    logic dcm1_rst_reg;
    logic dcm2_rst_reg;
    logic sys_rst_reg;
    logic ready_reg;
    logic fault_reg;

    always_comb begin
        state_next = state_reg;
        retry_next = retry_reg;
        loss_next  = loss_reg;
        fail       = 1'b0;
        timer_next = (timer_reg == '1) ? timer_reg : timer_reg + 1'b1;

        if (RESTART) begin
            state_next = S_RST1;
            retry_next = 3'd0;
        end else begin
            case (state_reg)
                S_RST1: begin
                    if (timer_reg == RST_LAST) begin
                        state_next = S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (l1s) begin
                        state_next = S_RST2;
                    end else if (timer_reg == LOCK_LAST) begin
                        fail = 1'b1;
                    end
                end
                S_RST2: begin
                    if (!l1s) begin
                        fail = 1'b1;
                    end else if (timer_reg == RST_LAST) begin
                        state_next = S_WAIT2;
                    end
                end
                S_WAIT2: begin
                    // A lock arriving in the last timeout cycle still wins.
                    if (!l1s) begin
                        fail = 1'b1;
                    end else if (l2s) begin
                        state_next = S_SETTLE;
                    end else if (timer_reg == LOCK_LAST) begin
                        fail = 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!(l1s && l2s)) begin
                        fail = 1'b1;
                    end else if (timer_reg == SETTLE_LAST) begin
                        state_next = S_RUN;
                        retry_next = 3'd0;
                    end
                end
                S_RUN: begin
                    // One loss event per exit, even when both locks drop together.
                    if (!l1s || !l2s) begin
                        state_next = l1s ? S_RST2 : S_RST1;
                        loss_next  = sat_inc8(loss_reg);
                    end
                end
                S_FAULT: begin
                    state_next = S_FAULT;
                end
                default: begin
                    state_next = S_RST1;
                end
            endcase

            if (fail) begin
                if (retry_reg + 3'd1 == MAX_RETRY_W) begin
                    state_next = S_FAULT;
                    retry_next = MAX_RETRY_W;
                end else begin
                    retry_next = retry_reg + 3'd1;
                    state_next = l1s ? S_RST2 : S_RST1;
                end
            end
        end

        if (RESTART || (state_next != state_reg)) begin
            timer_next = '0;
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_reg    <= S_RST1;
            timer_reg    <= '0;
            retry_reg    <= 3'd0;
            loss_reg     <= 8'd0;
            dcm1_rst_reg <= 1'b1;
            dcm2_rst_reg <= 1'b1;
            sys_rst_reg  <= 1'b1;
            ready_reg    <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            retry_reg    <= retry_next;
            loss_reg     <= loss_next;
            dcm1_rst_reg <= (state_next == S_RST1) || (state_next == S_FAULT);
            dcm2_rst_reg <= (state_next == S_RST1) || (state_next == S_WAIT1) ||
                            (state_next == S_RST2) || (state_next == S_FAULT);
            sys_rst_reg  <= (state_next != S_RUN);
            ready_reg    <= (state_next == S_RUN);
            fault_reg    <= (state_next == S_FAULT);
        end
    end

    assign DCM1_RST  = dcm1_rst_reg;
    assign DCM2_RST  = dcm2_rst_reg;
    assign SYS_RST   = sys_rst_reg;
    assign READY     = ready_reg;
    assign FAULT     = fault_reg;
    assign RETRY_CNT = retry_reg;
    assign LOSS_CNT  = loss_reg;

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Directed bench for dcm_lock_supervisor with a phase/age reference model and a DCM lock emulator.
module tb_dcm_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 100;
    localparam int SETTLE_CYCLES = 16;
    localparam int MAX_RETRY     = 2;
    localparam int CNT_W         = 16;

    localparam int SEL_READY     = 0;
    localparam int SEL_DCM2_LOW  = 1;
    localparam int SEL_DCM2_HIGH = 2;
    localparam int SEL_FAULT     = 3;
    localparam int SEL_SYS_RST   = 4;
    localparam int SEL_NOT_READY = 5;

    logic       BUS_CLK = 1'b0;
    logic       BUS_RST = 1'b1;
    logic       RESTART = 1'b0;
    logic       LOCKED1 = 1'b0;
    logic       LOCKED2 = 1'b0;
    logic       DCM1_RST;
    logic       DCM2_RST;
    logic       SYS_RST;
    logic       READY;
    logic       FAULT;
    logic [2:0] RETRY_CNT;
    logic [7:0] LOSS_CNT;

    dcm_lock_supervisor #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .MAX_RETRY     (MAX_RETRY),
        .CNT_W         (CNT_W)
    ) dut (
        .BUS_CLK   (BUS_CLK),
        .BUS_RST   (BUS_RST),
        .RESTART   (RESTART),
        .LOCKED1   (LOCKED1),
        .LOCKED2   (LOCKED2),
        .DCM1_RST  (DCM1_RST),
        .DCM2_RST  (DCM2_RST),
        .SYS_RST   (SYS_RST),
        .READY     (READY),
        .FAULT     (FAULT),
        .RETRY_CNT (RETRY_CNT),
        .LOSS_CNT  (LOSS_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: which phase the sequencer is in and how long it has been there.
    typedef enum logic [2:0] {P_RST1, P_WAIT1, P_RST2, P_WAIT2, P_SETTLE, P_RUN, P_FAULT} phase_e;

    typedef struct packed {
        phase_e ph;
        int     age;
        int     retries;
        int     losses;
        logic   a1;
        logic   b1;
        logic   a2;
        logic   b2;
    } mdl_t;

    function automatic mdl_t mdl_step(input mdl_t m, input logic rst, input logic rs,
                                      input logic lk1, input logic lk2);
        mdl_t   n;
        logic   l1;
        logic   l2;
        logic   failed;
        phase_e go;
        l1 = m.b1;
        l2 = m.b2;
        n = m;
        n.a1 = lk1;
        n.b1 = m.a1;
        n.a2 = lk2;
        n.b2 = m.a2;
        if (rst) begin
            n = '0;
            n.ph = P_RST1;
            return n;
        end
        if (rs) begin
            n.ph = P_RST1;
            n.age = 0;
            n.retries = 0;
            return n;
        end
        go = m.ph;
        failed = 1'b0;
        case (m.ph)
            P_RST1:   if (m.age + 1 >= RST_CYCLES) go = P_WAIT1;
            P_WAIT1:  if (l1) go = P_RST2;
                      else if (m.age + 1 >= LOCK_TIMEOUT) failed = 1'b1;
            P_RST2:   if (!l1) failed = 1'b1;
                      else if (m.age + 1 >= RST_CYCLES) go = P_WAIT2;
            P_WAIT2:  if (!l1) failed = 1'b1;
                      else if (l2) go = P_SETTLE;
                      else if (m.age + 1 >= LOCK_TIMEOUT) failed = 1'b1;
            P_SETTLE: if (!(l1 && l2)) failed = 1'b1;
                      else if (m.age + 1 >= SETTLE_CYCLES) go = P_RUN;
            P_RUN: begin
                if (!(l1 && l2)) begin
                    go = l1 ? P_RST2 : P_RST1;
                    n.losses = (m.losses >= 255) ? 255 : m.losses + 1;
                end
            end
            default: go = m.ph;
        endcase
        if (failed) begin
            if (m.retries + 1 >= MAX_RETRY) begin
                go = P_FAULT;
                n.retries = MAX_RETRY;
            end else begin
                n.retries = m.retries + 1;
                go = l1 ? P_RST2 : P_RST1;
            end
        end
        if (go == P_RUN && m.ph != P_RUN) n.retries = 0;
        n.age = (go != m.ph) ? 0 : m.age + 1;
        n.ph = go;
        return n;
    endfunction

    // {DCM1_RST, DCM2_RST, SYS_RST, READY, FAULT} implied by a phase.
    function automatic logic [4:0] mdl_outs(input phase_e ph);
        logic d1;
        logic d2;
        d1 = (ph == P_RST1) || (ph == P_FAULT);
        d2 = (ph != P_WAIT2) && (ph != P_SETTLE) && (ph != P_RUN);
        return {d1, d2, ph != P_RUN, ph == P_RUN, ph == P_FAULT};
    endfunction

    mdl_t m;
    bit   mdl_valid = 1'b0;

    always @(posedge BUS_CLK) begin
        m <= mdl_step(m, BUS_RST, RESTART, LOCKED1, LOCKED2);
        if (BUS_RST) mdl_valid <= 1'b1;
    end

    always @(negedge BUS_CLK) begin
        if (mdl_valid) begin
            chk("ctrl_outs", int'({DCM1_RST, DCM2_RST, SYS_RST, READY, FAULT}), int'(mdl_outs(m.ph)));
            chk("retry_cnt", int'(RETRY_CNT), m.retries);
            chk("loss_cnt", int'(LOSS_CNT), m.losses);
        end
    end

    // DCM emulator: LOCKEDx rises dx cycles after DCMx_RST falls (dx=0: never), gx forces low.
    int a1 = 0;
    int a2 = 0;
    int d1 = 10;
    int d2 = 10;
    int g1 = 0;
    int g2 = 0;

    task automatic drive_locks();
        LOCKED1 = (d1 != 0) && (a1 > d1) && (g1 == 0);
        LOCKED2 = (d2 != 0) && (a2 > d2) && (g2 == 0);
    endtask

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
        a1 = DCM1_RST ? 0 : ((a1 < 1000) ? a1 + 1 : a1);
        a2 = DCM2_RST ? 0 : ((a2 < 1000) ? a2 + 1 : a2);
        if (g1 > 0) g1--;
        if (g2 > 0) g2--;
        drive_locks();
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            SEL_READY:     return READY;
            SEL_DCM2_LOW:  return !DCM2_RST;
            SEL_DCM2_HIGH: return DCM2_RST;
            SEL_FAULT:     return FAULT;
            SEL_SYS_RST:   return SYS_RST;
            SEL_NOT_READY: return !READY;
            default:       return 1'b0;
        endcase
    endfunction

    task automatic count_to(input int sel, input int budget, input string what, output int n);
        n = 0;
        while (!cond(sel) && n < budget) begin
            tick();
            n++;
        end
        if (!cond(sel)) begin
            total++;
            bad++;
            $display("FAIL wait_%s: condition not reached within %0d cycles", what, budget);
        end
    endtask

    task automatic wait_phase(input phase_e ph, input int budget, input string what);
        int n = 0;
        while (m.ph != ph && n < budget) begin
            tick();
            n++;
        end
        if (m.ph != ph) begin
            total++;
            bad++;
            $display("FAIL wait_%s: phase not reached within %0d cycles", what, budget);
        end
    endtask

    task automatic pulse_restart();
        RESTART = 1'b1;
        tick();
        RESTART = 1'b0;
    endtask

    localparam int RESET_VEC = 16'b11100_000_00000000;

    function automatic int out_vec();
        return int'({DCM1_RST, DCM2_RST, SYS_RST, READY, FAULT, RETRY_CNT, LOSS_CNT});
    endfunction

    initial begin
        int n;
        repeat (3) tick();
        chk("reset_vec", out_vec(), RESET_VEC);
        BUS_RST = 1'b0;

        // 1: clean bring-up
        n = 0;
        while (DCM1_RST && n < 50) begin
            n++;
            tick();
        end
        chk("t1_dcm1_rst_width", n, 4);
        count_to(SEL_READY, 500, "t1_ready", n);
        chk("t1_dcm1_fall_to_ready", n, 46);
        chk("t1_sys_rst", int'(SYS_RST), 0);
        chk("t1_retry", int'(RETRY_CNT), 0);
        chk("t1_loss", int'(LOSS_CNT), 0);

        // 2: DCM_CMD never locks -> two timeouts then FAULT
        d2 = 0;
        pulse_restart();
        count_to(SEL_DCM2_LOW, 200, "t2_wait2", n);
        count_to(SEL_DCM2_HIGH, 300, "t2_timeout1", n);
        chk("t2_wait2_len", n, 100);
        chk("t2_retry1", int'(RETRY_CNT), 1);
        count_to(SEL_FAULT, 300, "t2_fault", n);
        chk("t2_retry2", int'(RETRY_CNT), 2);
        chk("t2_dcm_rsts", int'({DCM1_RST, DCM2_RST, SYS_RST}), 7);
        d2 = 10;
        pulse_restart();
        chk("t2_fault_cleared", int'(FAULT), 0);
        chk("t2_retry_cleared", int'(RETRY_CNT), 0);
        chk("t2_dcm1_rst", int'(DCM1_RST), 1);
        count_to(SEL_READY, 500, "t2_recover", n);

        // 3: LOCKED2 drops for 5 cycles in RUN
        g2 = 5;
        drive_locks();
        count_to(SEL_SYS_RST, 20, "t3_sys_rst", n);
        chk("t3_sys_rst_latency", n, 3);
        chk("t3_dcm1_rst", int'(DCM1_RST), 0);
        count_to(SEL_DCM2_LOW, 20, "t3_dcm2_pulse", n);
        chk("t3_dcm2_pulse_len", n, 4);
        chk("t3_loss", int'(LOSS_CNT), 1);
        count_to(SEL_READY, 500, "t3_recover", n);

        // 4: both locks drop together
        g1 = 5;
        g2 = 5;
        drive_locks();
        repeat (3) tick();
        chk("t4_dcm1_rst", int'(DCM1_RST), 1);
        chk("t4_loss", int'(LOSS_CNT), 2);
        count_to(SEL_READY, 500, "t4_recover", n);

        // 5: one-cycle LOCKED2 glitch during SETTLE
        pulse_restart();
        chk("t5_loss_kept", int'(LOSS_CNT), 2);
        wait_phase(P_SETTLE, 500, "t5_settle");
        repeat (10) tick();
        g2 = 1;
        drive_locks();
        count_to(SEL_DCM2_HIGH, 10, "t5_fail", n);
        chk("t5_retry", int'(RETRY_CNT), 1);
        count_to(SEL_DCM2_LOW, 20, "t5_wait2", n);
        count_to(SEL_READY, 100, "t5_ready", n);
        chk("t5_full_settle", n, 29);
        chk("t5_retry_run", int'(RETRY_CNT), 0);

        // 6: BUS_RST mid-WAIT2 and with LOSS_CNT=3, RESTART alongside
        pulse_restart();
        wait_phase(P_WAIT2, 200, "t6_wait2");
        repeat (3) tick();
        BUS_RST = 1'b1;
        RESTART = 1'b1;
        tick();
        chk("t6_reset_vec_a", out_vec(), RESET_VEC);
        RESTART = 1'b0;
        tick();
        chk("t6_reset_held", out_vec(), RESET_VEC);
        BUS_RST = 1'b0;
        count_to(SEL_READY, 500, "t6_up", n);
        repeat (3) begin
            g2 = 5;
            drive_locks();
            count_to(SEL_NOT_READY, 20, "t6_drop", n);
            count_to(SEL_READY, 200, "t6_relock", n);
        end
        chk("t6_loss3", int'(LOSS_CNT), 3);
        BUS_RST = 1'b1;
        RESTART = 1'b1;
        tick();
        chk("t6_reset_vec_b", out_vec(), RESET_VEC);
        BUS_RST = 1'b0;
        RESTART = 1'b0;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
